qar_uart_rx: RTL

//  RS-485/UART receive path of the qar_core UART peripheral; consumes the serial stream on

---
 rtl/qar_uart_pkg.sv | 20 ++
 rtl/qar_sync_fifo.sv | 60 ++++++
 rtl/qar_uart_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/qar_uart_pkg.sv
// Shared types and constants for the qar_core UART receive and transmit paths.
package qar_uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 7;
    localparam int unsigned SUB_W      = $clog2(OVERSAMPLE);

    // 2-of-3 vote across the three mid-bit samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/qar_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A pop on a full FIFO frees the slot that a same-cycle push then fills.
module qar_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr_q];
    assign level    = count_q;

    // Occupancy follows the net effect of push and pop
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/qar_uart_rx.sv
// UART receive path: 16x-oversampled 8N1 deserialiser feeding an FWFT FIFO,
// with sticky error flags and an idle-line interrupt armed by received bytes.
module qar_uart_rx
    import qar_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned IDLE_BITS  = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [15:0]                 baud_div,
    input  logic                        rx_en,
    input  logic                        uart_rx,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic                        flag_clr,
    output logic                        overrun,
    output logic                        frame_err,
    output logic                        idle_pend,
    output logic                        idle_irq
);

    localparam int unsigned IDLE_TICKS = IDLE_BITS * OVERSAMPLE;
    localparam int unsigned IW         = $clog2(IDLE_TICKS + 1);
    localparam logic [SUB_W-1:0] SUB_S0   = SUB_W'(SAMPLE_MID);
    localparam logic [SUB_W-1:0] SUB_S1   = SUB_W'(SAMPLE_MID + 1);
    localparam logic [SUB_W-1:0] SUB_S2   = SUB_W'(SAMPLE_MID + 2);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q, rx_prev_q;
    logic [15:0]      div_cnt_q, div_cnt_d, div_max;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             s7_q, s7_d, s8_q, s8_d;
    logic             idle_arm_q, idle_arm_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic             overrun_q, frame_err_q, idle_pend_q, idle_irq_q;
    logic             rx_s, fall, start_edge, running, tick;
    logic             push, ferr_set, idle_evt;
    logic             fifo_empty, fifo_full;

    assign rx_s       = sync2_q;
    assign fall       = rx_prev_q & ~rx_s;
    assign start_edge = (state_q == StIdle) & rx_en & fall;
    assign div_max    = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign running    = (state_q != StIdle) | idle_arm_q;
    // >= lets a lowered baud_div wrap at once instead of running the counter round
    assign tick       = running & (div_cnt_q >= div_max);

    // Oversample tick counter; parked at 0 when nothing needs timing
    always_comb begin
        div_cnt_d = div_cnt_q + 16'd1;
        if (start_edge || !running || tick) div_cnt_d = 16'd0;
    end

    // Frame FSM: start validation, mid-bit majority sampling, stop check
    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        s7_d     = s7_q;
        s8_d     = s8_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (!rx_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_d = StStart;
                        sub_d   = '0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        sub_d = sub_q + 1'b1;
                        if (sub_q == SUB_S0 && rx_s) begin
                            state_d = StIdle;
                        end else if (sub_q == SUB_LAST) begin
                            state_d = StData;
                            bit_d   = 3'd0;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        sub_d = sub_q + 1'b1;
                        if (sub_q == SUB_S0) s7_d = rx_s;
                        if (sub_q == SUB_S1) s8_d = rx_s;
                        if (sub_q == SUB_S2) shreg_d = {majority3(s7_q, s8_q, rx_s), shreg_q[7:1]};
                        if (sub_q == SUB_LAST) begin
                            if (bit_q == 3'd7) state_d = StStop;
                            else               bit_d   = bit_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        sub_d = sub_q + 1'b1;
                        if (sub_q == SUB_S0) s7_d = rx_s;
                        if (sub_q == SUB_S1) s8_d = rx_s;
                        // Leave early so a back-to-back start edge is not missed
                        if (sub_q == SUB_S2) begin
                            state_d = StIdle;
                            if (majority3(s7_q, s8_q, rx_s)) push     = 1'b1;
                            else                             ferr_set = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Idle timer: counts line-high ticks after a good byte, fires once
    always_comb begin
        idle_arm_d = idle_arm_q;
        idle_cnt_d = idle_cnt_q;
        idle_evt   = 1'b0;
        if (!rx_en) begin
            idle_arm_d = 1'b0;
            idle_cnt_d = '0;
        end else if (push) begin
            idle_arm_d = 1'b1;
            idle_cnt_d = '0;
        end else if (start_edge) begin
            idle_cnt_d = '0;
        end else if (idle_arm_q && state_q == StIdle && rx_s && tick) begin
            if (idle_cnt_q == IW'(IDLE_TICKS - 1)) begin
                idle_evt   = 1'b1;
                idle_arm_d = 1'b0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, FSM, timers and sticky flags (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            sub_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            idle_arm_q  <= 1'b0;
            idle_cnt_q  <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            idle_pend_q <= 1'b0;
            idle_irq_q  <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            sync2_q     <= sync1_q;
            rx_prev_q   <= sync2_q;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sub_q       <= sub_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            idle_arm_q  <= idle_arm_d;
            idle_cnt_q  <= idle_cnt_d;
            overrun_q   <= (push & fifo_full & ~rd_en) | (overrun_q & ~flag_clr);
            frame_err_q <= ferr_set | (frame_err_q & ~flag_clr);
            idle_pend_q <= idle_evt | (idle_pend_q & ~flag_clr);
            idle_irq_q  <= idle_evt;
        end
    end

    qar_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(shreg_q),
        .pop      (rd_en),
        .pop_data (rd_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    assign rd_valid  = ~fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign idle_pend = idle_pend_q;
    assign idle_irq  = idle_irq_q;

endmodule
